// File: rtl/custom_displays_axi_slave.sv
// CustomDisplays AXI4-Lite responder: four read/write registers that drive an
// 8-digit multiplexed seven-segment display (hex digits, points, blanking, scan rate).
module custom_displays_axi_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned NUM_DIGITS         = 8
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [6:0]                      seg_n,
    output logic                            dp_n,
    output logic [NUM_DIGITS-1:0]           an_n
);

    localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [4];

    logic                          aw_held_q, aw_held_d;
    logic [1:0]                    aw_sel_q, aw_sel_d;
    logic                          w_held_q, w_held_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]             w_strb_q, w_strb_d;
    logic                          bvalid_q, bvalid_d;
    logic                          awready_q, awready_d;
    logic                          wready_q, wready_d;
    logic                          arready_q, arready_d;
    logic                          rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [15:0]                   cnt_q, cnt_d;
    logic [2:0]                    idx_q, idx_d;
    logic [NUM_DIGITS-1:0]         an_q, an_d;
    logic [6:0]                    seg_q, seg_d;
    logic                          dp_q, dp_d;

    logic                          unused_inputs;
    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                             s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Write path: AW and W are captured independently, committed once both are held.
    always_comb begin
        regs_d    = regs_q;
        aw_held_d = aw_held_q;
        aw_sel_d  = aw_sel_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;

        if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (s00_axi_awvalid && awready_q) begin
            aw_held_d = 1'b1;
            aw_sel_d  = s00_axi_awaddr[3:2];
        end
        if (s00_axi_wvalid && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = s00_axi_wdata;
            w_strb_d = s00_axi_wstrb;
        end
        if (aw_held_q && w_held_q) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (w_strb_q[b]) begin
                    regs_d[aw_sel_q][8*b +: 8] = w_data_q[8*b +: 8];
                end
            end
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end

        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    // Read path samples regs_q, so a same-edge write is not yet visible.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end
        if (s00_axi_arvalid && arready_q) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[s00_axi_araddr[3:2]];
        end
        arready_d = !rvalid_d;
    end

    // Scan prescaler and digit output decode.
    always_comb begin
        logic digit_en;
        if (cnt_q >= regs_q[2][15:0]) begin
            cnt_d = '0;
            idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 16'd1;
            idx_d = idx_q;
        end

        digit_en = regs_q[1][{2'b01, idx_q}];
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            an_d[k] = !(digit_en && (idx_q == 3'(k)));
        end
        seg_d = digit_en ? hex_to_seg(regs_q[0][{idx_q, 2'b00} +: 4]) : 7'h7F;
        dp_d  = digit_en ? !regs_q[1][{2'b00, idx_q}] : 1'b1;
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            aw_held_q <= 1'b0;
            aw_sel_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            regs_q    <= regs_d;
            aw_held_q <= aw_held_d;
            aw_sel_q  <= aw_sel_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign s00_axi_rvalid  = rvalid_q;
    assign an_n            = an_q;
    assign seg_n           = seg_q;
    assign dp_n            = dp_q;

endmodule

// File: tb/tb_custom_displays_axi_slave.sv
// Self-checking bench for custom_displays_axi_slave: directed AXI scenarios, randomized
// register traffic against an array model, and a display scan check.
module tb_custom_displays_axi_slave;

    logic        s00_axi_aclk = 1'b0;
    logic        s00_axi_areset;
    logic [3:0]  s00_axi_awaddr;
    logic [2:0]  s00_axi_awprot;
    logic        s00_axi_awvalid;
    logic        s00_axi_awready;
    logic [31:0] s00_axi_wdata;
    logic [3:0]  s00_axi_wstrb;
    logic        s00_axi_wvalid;
    logic        s00_axi_wready;
    logic [1:0]  s00_axi_bresp;
    logic        s00_axi_bvalid;
    logic        s00_axi_bready;
    logic [3:0]  s00_axi_araddr;
    logic [2:0]  s00_axi_arprot;
    logic        s00_axi_arvalid;
    logic        s00_axi_arready;
    logic [31:0] s00_axi_rdata;
    logic [1:0]  s00_axi_rresp;
    logic        s00_axi_rvalid;
    logic        s00_axi_rready;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model [4];

    custom_displays_axi_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .NUM_DIGITS(8)
    ) dut (
        .s00_axi_aclk(s00_axi_aclk),
        .s00_axi_areset(s00_axi_areset),
        .s00_axi_awaddr(s00_axi_awaddr),
        .s00_axi_awprot(s00_axi_awprot),
        .s00_axi_awvalid(s00_axi_awvalid),
        .s00_axi_awready(s00_axi_awready),
        .s00_axi_wdata(s00_axi_wdata),
        .s00_axi_wstrb(s00_axi_wstrb),
        .s00_axi_wvalid(s00_axi_wvalid),
        .s00_axi_wready(s00_axi_wready),
        .s00_axi_bresp(s00_axi_bresp),
        .s00_axi_bvalid(s00_axi_bvalid),
        .s00_axi_bready(s00_axi_bready),
        .s00_axi_araddr(s00_axi_araddr),
        .s00_axi_arprot(s00_axi_arprot),
        .s00_axi_arvalid(s00_axi_arvalid),
        .s00_axi_arready(s00_axi_arready),
        .s00_axi_rdata(s00_axi_rdata),
        .s00_axi_rresp(s00_axi_rresp),
        .s00_axi_rvalid(s00_axi_rvalid),
        .s00_axi_rready(s00_axi_rready),
        .seg_n(seg_n),
        .dp_n(dp_n),
        .an_n(an_n)
    );

    always #5 s00_axi_aclk = ~s00_axi_aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Segment lit-sets: bit d of each mask is set when that segment is lit for hex digit d.
    function automatic logic [6:0] exp_seg(input logic [3:0] nib);
        logic [15:0] lit [7];
        logic [6:0]  r;
        lit = '{16'hD7ED, 16'h279F, 16'h2FFB, 16'h7B6D, 16'hFD45, 16'hDF71, 16'hEF7C};
        for (int s = 0; s < 7; s++) begin
            r[s] = !lit[s][nib];
        end
        return r;
    endfunction

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        bit seen    = 0;
        int t       = 0;
        s00_axi_awaddr = addr;
        s00_axi_wdata  = data;
        s00_axi_wstrb  = strb;
        while (!(aw_done && w_done) && t < 40) begin
            s00_axi_awvalid = !aw_done && (t >= aw_dly);
            s00_axi_wvalid  = !w_done && (t >= w_dly);
            aw_hs = s00_axi_awvalid && s00_axi_awready;
            w_hs  = s00_axi_wvalid && s00_axi_wready;
            @(negedge s00_axi_aclk);
            aw_done |= aw_hs;
            w_done  |= w_hs;
            t++;
        end
        s00_axi_awvalid = 1'b0;
        s00_axi_wvalid  = 1'b0;
        check("write_accepted", 32'({aw_done, w_done}), 32'h3);
        for (int i = 0; i < 4 && !seen; i++) begin
            if (s00_axi_bvalid) seen = 1;
            else @(negedge s00_axi_aclk);
        end
        check("bvalid_seen", 32'(seen), 32'h1);
        check("bresp", 32'(s00_axi_bresp), 32'h0);
        model_write(addr, data, strb);
        repeat (b_dly) @(negedge s00_axi_aclk);
        check("bvalid_hold", 32'(s00_axi_bvalid), 32'h1);
        s00_axi_bready = 1'b1;
        @(negedge s00_axi_aclk);
        s00_axi_bready = 1'b0;
        check("bvalid_drop", 32'(s00_axi_bvalid), 32'h0);
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr,
                              input logic [31:0] exp, input int r_dly);
        bit hs = 0;
        int t  = 0;
        s00_axi_araddr  = addr;
        s00_axi_arvalid = 1'b1;
        while (!hs && t < 20) begin
            hs = s00_axi_arready;
            @(negedge s00_axi_aclk);
            t++;
        end
        s00_axi_arvalid = 1'b0;
        check("ar_accepted", 32'(hs), 32'h1);
        check("rvalid_latency", 32'(s00_axi_rvalid), 32'h1);
        check(tag, s00_axi_rdata, exp);
        check("rresp", 32'(s00_axi_rresp), 32'h0);
        repeat (r_dly) @(negedge s00_axi_aclk);
        check("rdata_hold", s00_axi_rdata, exp);
        s00_axi_rready = 1'b1;
        @(negedge s00_axi_aclk);
        s00_axi_rready = 1'b0;
        check("rvalid_drop", 32'(s00_axi_rvalid), 32'h0);
    endtask

    task automatic disp_check(input int d);
        bit         en = model[1][8 + d];
        logic [7:0] exp_an;
        exp_an    = 8'hFF;
        exp_an[d] = !en;
        check("an_n", 32'(an_n), 32'(exp_an));
        check("seg_n", 32'(seg_n), en ? 32'(exp_seg(model[0][4*d +: 4])) : 32'h7F);
        check("dp_n", 32'(dp_n), en ? 32'(!model[1][d]) : 32'h1);
    endtask

    initial begin
        logic [7:0] prev_an, cur_an;
        bit         synced;
        logic [3:0] a;

        s00_axi_areset  = 1'b1;
        s00_axi_awaddr  = '0;
        s00_axi_awprot  = '0;
        s00_axi_awvalid = 1'b0;
        s00_axi_wdata   = '0;
        s00_axi_wstrb   = '0;
        s00_axi_wvalid  = 1'b0;
        s00_axi_bready  = 1'b0;
        s00_axi_araddr  = '0;
        s00_axi_arprot  = '0;
        s00_axi_arvalid = 1'b0;
        s00_axi_rready  = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;

        // Reset state
        repeat (2) @(negedge s00_axi_aclk);
        check("rst_awready", 32'(s00_axi_awready), 32'h0);
        check("rst_wready", 32'(s00_axi_wready), 32'h0);
        check("rst_bvalid", 32'(s00_axi_bvalid), 32'h0);
        check("rst_arready", 32'(s00_axi_arready), 32'h0);
        check("rst_rvalid", 32'(s00_axi_rvalid), 32'h0);
        check("rst_rdata", s00_axi_rdata, 32'h0);
        check("rst_an_n", 32'(an_n), 32'hFF);
        check("rst_seg_n", 32'(seg_n), 32'h7F);
        check("rst_dp_n", 32'(dp_n), 32'h1);
        s00_axi_areset = 1'b0;
        @(negedge s00_axi_aclk);
        check("idle_awready", 32'(s00_axi_awready), 32'h1);
        check("idle_arready", 32'(s00_axi_arready), 32'h1);

        // Sequential write/readback
        for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) read_check("seq_read", 4'(i * 4), 32'(i + 1), 0);

        // Byte strobes
        axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(4'hC, 32'h1234_5678, 4'b0101, 0, 0, 0);
        read_check("strobe_read", 4'hC, 32'hFF34_FF78, 1);
        axi_write(4'hC, 32'hDEAD_BEEF, 4'h0, 0, 0, 0);
        read_check("strobe_none", 4'hC, 32'hFF34_FF78, 0);

        // Decoupled channels: W five cycles ahead of AW, bready delayed
        s00_axi_wdata  = 32'h0D0D_0D0D;
        s00_axi_wstrb  = 4'hF;
        s00_axi_wvalid = 1'b1;
        check("dec_wready", 32'(s00_axi_wready), 32'h1);
        @(negedge s00_axi_aclk);
        s00_axi_wvalid = 1'b0;
        check("dec_w_held", 32'(s00_axi_wready), 32'h0);
        repeat (4) @(negedge s00_axi_aclk);
        check("dec_no_early_b", 32'(s00_axi_bvalid), 32'h0);
        s00_axi_awaddr  = 4'hC;
        s00_axi_awvalid = 1'b1;
        check("dec_awready", 32'(s00_axi_awready), 32'h1);
        @(negedge s00_axi_aclk);
        s00_axi_awvalid = 1'b0;
        check("dec_b_not_yet", 32'(s00_axi_bvalid), 32'h0);
        @(negedge s00_axi_aclk);
        for (int i = 0; i < 3; i++) begin
            check("dec_bvalid", 32'(s00_axi_bvalid), 32'h1);
            check("dec_ready_block", 32'({s00_axi_awready, s00_axi_wready}), 32'h0);
            @(negedge s00_axi_aclk);
        end
        s00_axi_bready = 1'b1;
        @(negedge s00_axi_aclk);
        s00_axi_bready = 1'b0;
        check("dec_bvalid_drop", 32'(s00_axi_bvalid), 32'h0);
        check("dec_ready_back", 32'({s00_axi_awready, s00_axi_wready}), 32'h3);
        model[3] = 32'h0D0D_0D0D;
        read_check("dec_read", 4'hC, 32'h0D0D_0D0D, 0);

        // Same-edge read and write commit to REG0
        axi_write(4'h0, 32'hA, 4'hF, 0, 0, 0);
        s00_axi_awaddr  = 4'h0;
        s00_axi_wdata   = 32'hB;
        s00_axi_wstrb   = 4'hF;
        s00_axi_awvalid = 1'b1;
        s00_axi_wvalid  = 1'b1;
        @(negedge s00_axi_aclk);
        s00_axi_awvalid = 1'b0;
        s00_axi_wvalid  = 1'b0;
        s00_axi_araddr  = 4'h0;
        s00_axi_arvalid = 1'b1;
        check("same_arready", 32'(s00_axi_arready), 32'h1);
        @(negedge s00_axi_aclk);
        s00_axi_arvalid = 1'b0;
        check("same_bvalid", 32'(s00_axi_bvalid), 32'h1);
        check("same_rvalid", 32'(s00_axi_rvalid), 32'h1);
        check("same_rdata_old", s00_axi_rdata, 32'hA);
        s00_axi_bready = 1'b1;
        s00_axi_rready = 1'b1;
        @(negedge s00_axi_aclk);
        s00_axi_bready = 1'b0;
        s00_axi_rready = 1'b0;
        model[0] = 32'hB;
        read_check("same_rdata_new", 4'h0, 32'hB, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end else begin
                read_check("rand_read", a, model[a[3:2]], int'($urandom_range(0, 3)));
            end
        end

        // Display scan
        axi_write(4'h0, 32'h7654_3210, 4'hF, 0, 0, 0);
        axi_write(4'h4, 32'h0000_FF01, 4'hF, 0, 0, 0);
        axi_write(4'h8, 32'h0000_0003, 4'hF, 0, 0, 0);
        synced = 0;
        cur_an = an_n;
        for (int i = 0; i < 200 && !synced; i++) begin
            @(negedge s00_axi_aclk);
            prev_an = cur_an;
            cur_an  = an_n;
            if (prev_an == 8'hFE && cur_an == 8'hFD) synced = 1;
        end
        check("scan_sync", 32'(synced), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            disp_check(k % 8);
            repeat (4) @(negedge s00_axi_aclk);
        end

        // Blank digit 0
        axi_write(4'h4, 32'h0000_FE01, 4'hF, 0, 0, 0);
        synced = 0;
        cur_an = an_n;
        for (int i = 0; i < 200 && !synced; i++) begin
            @(negedge s00_axi_aclk);
            prev_an = cur_an;
            cur_an  = an_n;
            if (prev_an == 8'h7F && cur_an != 8'h7F) synced = 1;
        end
        check("blank_sync", 32'(synced), 32'h1);
        disp_check(0);
        check("blank_seg", 32'(seg_n), 32'h7F);
        repeat (4) @(negedge s00_axi_aclk);
        disp_check(1);

        // Reset asserted after AW handshake, before W
        axi_write(4'h0, 32'h5A5A_5A5A, 4'hF, 0, 0, 0);
        s00_axi_awaddr  = 4'h0;
        s00_axi_awvalid = 1'b1;
        @(negedge s00_axi_aclk);
        s00_axi_awvalid = 1'b0;
        s00_axi_areset  = 1'b1;
        #1;
        check("mid_rst_ready", 32'({s00_axi_awready, s00_axi_wready, s00_axi_arready}), 32'h0);
        check("mid_rst_valid", 32'({s00_axi_bvalid, s00_axi_rvalid}), 32'h0);
        check("mid_rst_an_n", 32'(an_n), 32'hFF);
        @(negedge s00_axi_aclk);
        s00_axi_areset = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        @(negedge s00_axi_aclk);
        read_check("mid_rst_reg0", 4'h0, 32'h0, 0);
        read_check("mid_rst_reg2", 4'h8, 32'h0, 0);
        axi_write(4'h0, 32'hCAFE_F00D, 4'hF, 1, 0, 1);
        read_check("post_rst_write", 4'h0, 32'hCAFE_F00D, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
